// File: rtl/axi_burst_split_pkg.sv
// Shared AXI address-channel constants and the burst splitter's state encoding.
package axi_burst_split_pkg;

    localparam int AXI_LEN_WIDTH           = 8;
    localparam int AXI_LEN_MAX_VALUE       = 256;
    localparam int AXI_FIXED_LEN_MAX_VALUE = 16;
    localparam int AXI_LEN_MAX_BYTES       = 4096;

    localparam logic [11:0] AXI_4K_BOUNDARY_MASK = 12'hFFF;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10,
        AXI_BURST_RSVD  = 2'b11
    } axi_burst_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ISSUE = 2'd2
    } axi_burst_split_state_e;

endpackage

// File: rtl/axi_burst_split_calc.sv
// Combinational beat count for the next burst: min of remaining beats, the
// configured cap, and the mode cap (4 KB boundary for INCR, 16 beats for FIXED).
module axi_burst_split_calc
    import axi_burst_split_pkg::*;
#(
    parameter int DW        = 32,
    parameter int BC_W      = 32,
    parameter int MAX_BEATS = 256
) (
    input  logic [BC_W-1:0]        remaining,
    input  logic [11:0]            addr_low,
    input  logic                   fixed,
    output logic [AXI_LEN_WIDTH:0] beats,
    output logic                   last
);

    localparam int SIZE = $clog2(DW / 8);
    localparam logic [AXI_LEN_WIDTH:0] MAX_CAP   = (AXI_LEN_WIDTH + 1)'(MAX_BEATS);
    localparam logic [AXI_LEN_WIDTH:0] FIXED_CAP = (AXI_LEN_WIDTH + 1)'(AXI_FIXED_LEN_MAX_VALUE);
    localparam logic [AXI_LEN_WIDTH:0] LEN_CAP   = (AXI_LEN_WIDTH + 1)'(AXI_LEN_MAX_VALUE);

    logic [12:0]            boundary_bytes;
    logic [12:0]            boundary_beats;
    logic [AXI_LEN_WIDTH:0] mode_cap;
    logic [AXI_LEN_WIDTH:0] limit;

    // An unaligned start close to the boundary can leave less than one full
    // beat before it; such a burst still issues a single beat so progress is made.
    always_comb begin
        boundary_bytes = 13'(AXI_LEN_MAX_BYTES) - {1'b0, addr_low & AXI_4K_BOUNDARY_MASK};
        boundary_beats = boundary_bytes >> SIZE;

        if (fixed) begin
            mode_cap = FIXED_CAP;
        end else if (boundary_beats > 13'(AXI_LEN_MAX_VALUE)) begin
            mode_cap = LEN_CAP;
        end else begin
            mode_cap = boundary_beats[AXI_LEN_WIDTH:0];
        end

        limit = (mode_cap < MAX_CAP) ? mode_cap : MAX_CAP;

        if (remaining < BC_W'(limit)) begin
            beats = remaining[AXI_LEN_WIDTH:0];
        end else begin
            beats = limit;
        end

        if (beats == '0 && remaining != '0) begin
            beats = (AXI_LEN_WIDTH + 1)'(1);
        end

        last = (BC_W'(beats) == remaining);
    end

endmodule

// File: rtl/axi_burst_split.sv
// Splits a linear transfer request into AXI-legal AR/AW burst commands.
// Define AXI_BURST_SPLIT_ALIGN_CHECK_EN to reject unaligned requests with err.
module axi_burst_split
    import axi_burst_split_pkg::*;
#(
    parameter int AW        = 64,
    parameter int DW        = 32,
    parameter int BC_W      = 32,
    parameter int MAX_BEATS = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [AW-1:0]            req_addr,
    input  logic [BC_W-1:0]          req_byte_cnt,
    input  logic                     req_fixed,
    output logic                     burst_valid,
    input  logic                     burst_ready,
    output logic [AW-1:0]            burst_addr,
    output logic [AXI_LEN_WIDTH-1:0] burst_len,
    output logic [2:0]               burst_size,
    output logic [1:0]               burst_type,
    output logic                     burst_last,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int SIZE = $clog2(DW / 8);

    axi_burst_split_state_e state_q, state_d;

    logic [AW-1:0]          addr_q;
    logic [BC_W-1:0]        remaining_q;
    logic                   fixed_q;
    logic [AXI_LEN_WIDTH:0] beats_q;
    logic [AXI_LEN_WIDTH:0] calc_beats;
    logic                   calc_last;
    logic                   req_bad;
    logic                   req_skip;

`ifdef AXI_BURST_SPLIT_ALIGN_CHECK_EN
    logic err_q;

    assign req_bad = (req_addr[SIZE-1:0] != '0) || (req_byte_cnt[SIZE-1:0] != '0);
    assign err     = err_q;
`else
    assign req_bad = 1'b0;
    assign err     = 1'b0;
`endif

    assign req_skip    = req_bad || ((req_byte_cnt >> SIZE) == '0);
    assign req_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign burst_valid = (state_q == ISSUE);

    axi_burst_split_calc #(
        .DW        (DW),
        .BC_W      (BC_W),
        .MAX_BEATS (MAX_BEATS)
    ) u_calc (
        .remaining (remaining_q),
        .addr_low  (addr_q[11:0]),
        .fixed     (fixed_q),
        .beats     (calc_beats),
        .last      (calc_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A request with nothing to send (zero beats or rejected) arrives in CALC
    // with remaining cleared and falls straight back to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                state_d = (remaining_q == '0) ? IDLE : ISSUE;
            end
            ISSUE: begin
                if (burst_ready) begin
                    state_d = burst_last ? IDLE : CALC;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            remaining_q <= '0;
            fixed_q     <= 1'b0;
            beats_q     <= '0;
            burst_addr  <= '0;
            burst_len   <= '0;
            burst_size  <= '0;
            burst_type  <= '0;
            burst_last  <= 1'b0;
            done        <= 1'b0;
`ifdef AXI_BURST_SPLIT_ALIGN_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef AXI_BURST_SPLIT_ALIGN_CHECK_EN
            err_q <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q      <= req_addr;
                        remaining_q <= req_bad ? '0 : (req_byte_cnt >> SIZE);
                        fixed_q     <= req_fixed;
                        done        <= req_skip;
`ifdef AXI_BURST_SPLIT_ALIGN_CHECK_EN
                        err_q       <= req_bad;
`endif
                    end
                end
                CALC: begin
                    if (remaining_q != '0) begin
                        burst_addr <= addr_q;
                        burst_len  <= AXI_LEN_WIDTH'(calc_beats - 1'b1);
                        burst_size <= 3'(SIZE);
                        burst_type <= fixed_q ? AXI_BURST_FIXED : AXI_BURST_INCR;
                        burst_last <= calc_last;
                        beats_q    <= calc_beats;
                    end
                end
                ISSUE: begin
                    // FIXED bursts all target the same address; INCR walks the full width.
                    if (burst_ready) begin
                        remaining_q <= remaining_q - BC_W'(beats_q);
                        if (!fixed_q) begin
                            addr_q <= addr_q + (AW'(beats_q) << SIZE);
                        end
                        done <= burst_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
